// File: rtl/pipe_chain_reg.sv
// pipe_chain_reg: stall/flush-controlled pipeline register chain with a two-port forwarding and hazard query
module pipe_chain_reg #(
    parameter int STAGES = 2,
    parameter int DATA_W = 32,
    parameter int SIDE_W = 8,
    parameter int TNEW_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] en,
    input  logic [STAGES-1:0] flush,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_res,
    input  logic [4:0]        in_a3,
    input  logic              in_write,
    input  logic [SIDE_W-1:0] in_side,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_res,
    output logic [4:0]        out_a3,
    output logic              out_write,
    output logic [SIDE_W-1:0] out_side,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [STAGES-1:0] stg_valid,
    input  logic [4:0]        q_addr0,
    input  logic [4:0]        q_addr1,
    input  logic [TNEW_W-1:0] q_tuse0,
    input  logic [TNEW_W-1:0] q_tuse1,
    output logic              q_hit0,
    output logic              q_hit1,
    output logic [DATA_W-1:0] q_data0,
    output logic [DATA_W-1:0] q_data1,
    output logic              q_stall0,
    output logic              q_stall1
);
    logic [STAGES-1:0] valid_q, valid_d, write_q, write_d, src_valid, src_write;
    logic [DATA_W-1:0] pc_q [STAGES], pc_d [STAGES], src_pc [STAGES];
    logic [DATA_W-1:0] instr_q [STAGES], instr_d [STAGES], src_instr [STAGES];
    logic [DATA_W-1:0] res_q [STAGES], res_d [STAGES], src_res [STAGES];
    logic [4:0]        a3_q [STAGES], a3_d [STAGES], src_a3 [STAGES];
    logic [SIDE_W-1:0] side_q [STAGES], side_d [STAGES], src_side [STAGES];
    logic [TNEW_W-1:0] tnew_q [STAGES], tnew_d [STAGES], src_tnew [STAGES];
    logic [4:0]        qa [2];
    logic [TNEW_W-1:0] qt [2];
    logic [1:0]        hit, stall;
    logic [DATA_W-1:0] qd [2];

    // Stage sources: the inputs feed stage 0, every later stage reads its predecessor
    always_comb begin
        src_valid    = '0;
        src_write    = '0;
        src_valid[0] = 1'b1;
        src_write[0] = in_write;
        src_pc[0]    = in_pc;
        src_instr[0] = in_instr;
        src_res[0]   = in_res;
        src_a3[0]    = in_a3;
        src_side[0]  = in_side;
        src_tnew[0]  = in_tnew;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid_q[i-1];
            src_write[i] = write_q[i-1];
            src_pc[i]    = pc_q[i-1];
            src_instr[i] = instr_q[i-1];
            src_res[i]   = res_q[i-1];
            src_a3[i]    = a3_q[i-1];
            src_side[i]  = side_q[i-1];
            src_tnew[i]  = tnew_q[i-1];
        end
    end

    // Next state: flush inserts a bubble (pc kept for exceptions), enable loads with Tnew countdown, else hold
    always_comb begin
        valid_d = valid_q;
        write_d = write_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        res_d   = res_q;
        a3_d    = a3_q;
        side_d  = side_q;
        tnew_d  = tnew_q;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i] || en[i]) begin
                pc_d[i]   = src_pc[i];
                res_d[i]  = src_res[i];
                side_d[i] = src_side[i];
            end
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                write_d[i] = 1'b0;
                a3_d[i]    = '0;
                tnew_d[i]  = '0;
                instr_d[i] = '0;
            end else if (en[i]) begin
                valid_d[i] = src_valid[i];
                write_d[i] = src_write[i] && (src_a3[i] != 5'd0);
                a3_d[i]    = src_a3[i];
                instr_d[i] = src_instr[i];
                tnew_d[i]  = (src_tnew[i] == '0) ? '0 : src_tnew[i] - TNEW_W'(1);
            end
        end
    end

    // State registers, cleared immediately when reset drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            write_q <= '0;
            pc_q    <= '{default: '0};
            instr_q <= '{default: '0};
            res_q   <= '{default: '0};
            a3_q    <= '{default: '0};
            side_q  <= '{default: '0};
            tnew_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            res_q   <= res_d;
            a3_q    <= a3_d;
            side_q  <= side_d;
            tnew_q  <= tnew_d;
        end
    end

    assign qa[0] = q_addr0;
    assign qa[1] = q_addr1;
    assign qt[0] = q_tuse0;
    assign qt[1] = q_tuse1;

    // Hazard lookup from registered state: scan oldest to youngest so the youngest matching stage decides
    always_comb begin
        hit   = '0;
        stall = '0;
        qd[0] = '0;
        qd[1] = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (valid_q[i] && write_q[i] && a3_q[i] == qa[p] && qa[p] != 5'd0) begin
                    hit[p]   = tnew_q[i] == '0;
                    stall[p] = tnew_q[i] > qt[p];
                    qd[p]    = (tnew_q[i] == '0) ? res_q[i] : '0;
                end
            end
        end
    end

    assign q_hit0    = hit[0];
    assign q_hit1    = hit[1];
    assign q_stall0  = stall[0];
    assign q_stall1  = stall[1];
    assign q_data0   = qd[0];
    assign q_data1   = qd[1];
    assign out_pc    = pc_q[STAGES-1];
    assign out_instr = instr_q[STAGES-1];
    assign out_res   = res_q[STAGES-1];
    assign out_a3    = a3_q[STAGES-1];
    assign out_write = write_q[STAGES-1];
    assign out_side  = side_q[STAGES-1];
    assign out_tnew  = tnew_q[STAGES-1];
    assign stg_valid = valid_q;
endmodule

// File: tb/tb_pipe_chain_reg.sv
// tb_pipe_chain_reg: randomized and directed checks of pipe_chain_reg against a behavioural stage-list model
module tb_pipe_chain_reg;
    localparam int S  = 2;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int TW = 4;
    localparam int OW = 3 * DW + 5 + 1 + SW + TW + S;
    localparam int QW = 2 * (DW + 2);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [S-1:0]  en = '0, flush = '0;
    logic [DW-1:0] in_pc = '0, in_instr = '0, in_res = '0;
    logic [4:0]    in_a3 = '0;
    logic          in_write = 1'b0;
    logic [SW-1:0] in_side = '0;
    logic [TW-1:0] in_tnew = '0;
    logic [DW-1:0] out_pc, out_instr, out_res;
    logic [4:0]    out_a3;
    logic          out_write;
    logic [SW-1:0] out_side;
    logic [TW-1:0] out_tnew;
    logic [S-1:0]  stg_valid;
    logic [4:0]    q_addr0 = '0, q_addr1 = '0;
    logic [TW-1:0] q_tuse0 = '0, q_tuse1 = '0;
    logic          q_hit0, q_hit1, q_stall0, q_stall1;
    logic [DW-1:0] q_data0, q_data1;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic          v;
        logic          w;
        logic [4:0]    a3;
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic [DW-1:0] res;
        logic [SW-1:0] side;
        logic [TW-1:0] tnew;
    } ent_t;

    ent_t m [S];

    pipe_chain_reg #(.STAGES(S), .DATA_W(DW), .SIDE_W(SW), .TNEW_W(TW)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_pc(in_pc), .in_instr(in_instr), .in_res(in_res), .in_a3(in_a3),
        .in_write(in_write), .in_side(in_side), .in_tnew(in_tnew),
        .out_pc(out_pc), .out_instr(out_instr), .out_res(out_res), .out_a3(out_a3),
        .out_write(out_write), .out_side(out_side), .out_tnew(out_tnew), .stg_valid(stg_valid),
        .q_addr0(q_addr0), .q_addr1(q_addr1), .q_tuse0(q_tuse0), .q_tuse1(q_tuse1),
        .q_hit0(q_hit0), .q_hit1(q_hit1), .q_data0(q_data0), .q_data1(q_data1),
        .q_stall0(q_stall0), .q_stall1(q_stall1)
    );

    always #5 clk = ~clk;

    function automatic ent_t src(int i);
        ent_t e;
        if (i == 0) e = '{v: 1'b1, w: in_write, a3: in_a3, pc: in_pc, instr: in_instr,
                          res: in_res, side: in_side, tnew: in_tnew};
        else e = m[i-1];
        return e;
    endfunction

    function automatic logic [OW-1:0] exp_out();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = m[i].v;
        return {m[S-1].pc, m[S-1].instr, m[S-1].res, m[S-1].a3, m[S-1].w, m[S-1].side, m[S-1].tnew, v};
    endfunction

    function automatic logic [DW+1:0] qm(logic [4:0] a, logic [TW-1:0] t);
        for (int i = 0; i < S; i++)
            if (a != 0 && m[i].v && m[i].w && m[i].a3 == a) begin
                if (m[i].tnew == 0) return {1'b1, 1'b0, m[i].res};
                if (m[i].tnew > t) return {1'b0, 1'b1, {DW{1'b0}}};
                return '0;
            end
        return '0;
    endfunction

    function automatic logic [OW-1:0] obs_out();
        return {out_pc, out_instr, out_res, out_a3, out_write, out_side, out_tnew, stg_valid};
    endfunction

    function automatic logic [QW-1:0] obs_q();
        return {q_hit0, q_stall0, q_data0, q_hit1, q_stall1, q_data1};
    endfunction

    function automatic logic [QW-1:0] exp_q();
        return {qm(q_addr0, q_tuse0), qm(q_addr1, q_tuse1)};
    endfunction

    task automatic tick();
        ent_t nm [S];
        for (int i = 0; i < S; i++) begin
            ent_t s;
            s = src(i);
            if (flush[i]) begin
                nm[i] = '0;
                nm[i].pc = s.pc;
                nm[i].res = s.res;
                nm[i].side = s.side;
            end else if (en[i]) begin
                nm[i] = s;
                nm[i].w = s.w && s.a3 != 0;
                nm[i].tnew = (s.tnew == 0) ? '0 : s.tnew - 1;
            end else nm[i] = m[i];
        end
        @(posedge clk);
        m = nm;
        #1;
    endtask

    task automatic rand_in();
        in_pc    = $urandom;
        in_instr = $urandom;
        in_res   = $urandom;
        in_a3    = 5'($urandom_range(0, 7));
        in_write = 1'($urandom);
        in_side  = 8'($urandom);
        in_tnew  = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_out() !== '0 || obs_q() !== '0) begin
            bad++;
            $display("FAIL reset_initial got=%h/%h exp=0", obs_out(), obs_q());
        end
        @(negedge clk) reset = 1'b1;
        en = '1;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            in_write = 1'b1;
            in_a3 = 5'd3;
            tick();
        end
        q_addr0 = 5'd3;
        @(negedge clk) reset = 1'b0;
        #1;
        for (int i = 0; i < S; i++) m[i] = '0;
        total++;
        if (obs_out() !== '0 || stg_valid !== '0 || obs_q() !== '0) begin
            bad++;
            $display("FAIL reset_midstream got=%h/%h exp=0", obs_out(), obs_q());
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_tnew_forward();
        en = 2'b11;
        flush = '0;
        rand_in();
        in_a3 = 5'd5;
        in_write = 1'b1;
        in_tnew = 4'd3;
        tick();
        in_a3 = 5'd0;
        in_write = 1'b0;
        tick();
        q_addr0 = 5'd5;
        q_tuse0 = 4'd0;
        q_addr1 = 5'd5;
        q_tuse1 = 4'd1;
        #1;
        total++;
        if (out_tnew !== 4'd1 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL tnew_countdown got=%h exp=%h", obs_out(), exp_out());
        end
        total++;
        if (q_stall0 !== 1'b1 || q_hit1 !== 1'b0 || q_stall1 !== 1'b0 || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL tnew_stall got=%h exp=%h", obs_q(), exp_q());
        end
        en = 2'b01;
        in_a3 = 5'd5;
        in_write = 1'b1;
        in_tnew = 4'd1;
        in_res = 32'h1234_5678;
        tick();
        total++;
        if (q_hit0 !== 1'b1 || q_data0 !== 32'h1234_5678 || q_stall0 !== 1'b0 || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL tnew_hit got=%h exp=%h", obs_q(), exp_q());
        end
    endtask

    task automatic test_stall();
        en = 2'b11;
        rand_in();
        in_a3 = 5'd6;
        in_write = 1'b1;
        in_tnew = 4'd4;
        tick();
        tick();
        en = 2'b01;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            q_addr0 = in_a3;
            q_tuse0 = 4'($urandom_range(0, 3));
            q_addr1 = 5'd6;
            q_tuse1 = 4'd1;
            tick();
            total++;
            if (out_tnew !== 4'd2 || obs_out() !== exp_out() || obs_q() !== exp_q()) begin
                bad++;
                $display("FAIL stall_hold k=%0d got=%h/%h exp=%h/%h", k, obs_out(), obs_q(), exp_out(), exp_q());
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] pc_b;
        en = 2'b11;
        flush = '0;
        rand_in();
        in_a3 = 5'd9;
        in_write = 1'b1;
        in_tnew = 4'd0;
        tick();
        rand_in();
        in_a3 = 5'd3;
        in_write = 1'b1;
        pc_b = in_pc;
        tick();
        q_addr0 = 5'd9;
        q_tuse0 = 4'd0;
        #1;
        total++;
        if (q_hit0 !== 1'b1 || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL flush_prehit got=%h exp=%h", obs_q(), exp_q());
        end
        flush = 2'b10;
        rand_in();
        in_a3 = 5'd4;
        tick();
        flush = '0;
        total++;
        if (stg_valid[1] !== 1'b0 || out_write !== 1'b0 || out_a3 !== 5'd0 || out_pc !== pc_b
            || out_instr !== '0 || out_tnew !== '0 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL flush_bubble got=%h exp=%h", obs_out(), exp_out());
        end
        total++;
        if (q_hit0 !== 1'b0 || q_stall0 !== 1'b0 || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL flush_nohit got=%h exp=%h", obs_q(), exp_q());
        end
    endtask

    task automatic test_nearest();
        en = 2'b11;
        rand_in();
        in_a3 = 5'd7;
        in_write = 1'b1;
        in_tnew = 4'd0;
        in_res = 32'h0000_BBBB;
        tick();
        in_res = 32'h0000_AAAA;
        tick();
        q_addr0 = 5'd7;
        q_addr1 = 5'd7;
        q_tuse1 = 4'd5;
        #1;
        total++;
        if (q_data0 !== 32'h0000_AAAA || q_data1 !== 32'h0000_AAAA || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL nearest got=%h exp=%h", obs_q(), exp_q());
        end
        in_a3 = 5'd0;
        in_write = 1'b1;
        tick();
        tick();
        q_addr0 = 5'd0;
        #1;
        total++;
        if (out_write !== 1'b0 || q_hit0 !== 1'b0 || obs_out() !== exp_out() || obs_q() !== exp_q()) begin
            bad++;
            $display("FAIL a3_zero got=%h/%h exp=%h/%h", obs_out(), obs_q(), exp_out(), exp_q());
        end
    endtask

    task automatic test_saturation();
        en = 2'b11;
        rand_in();
        in_tnew = 4'd0;
        tick();
        tick();
        total++;
        if (out_tnew !== 4'd0 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL sat_zero got=%h exp=%h", obs_out(), exp_out());
        end
        in_tnew = 4'd15;
        tick();
        tick();
        total++;
        if (out_tnew !== 4'd13 || obs_out() !== exp_out()) begin
            bad++;
            $display("FAIL sat_max got=%0d exp=13", out_tnew);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_in();
            en      = 2'($urandom);
            flush   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : '0;
            q_addr0 = 5'($urandom_range(0, 7));
            q_addr1 = 5'($urandom_range(0, 7));
            q_tuse0 = 4'($urandom_range(0, 15));
            q_tuse1 = 4'($urandom_range(0, 15));
            tick();
            total++;
            if (obs_out() !== exp_out()) begin
                bad++;
                $display("FAIL rand_out k=%0d got=%h exp=%h", k, obs_out(), exp_out());
            end
            total++;
            if (obs_q() !== exp_q()) begin
                bad++;
                $display("FAIL rand_query k=%0d got=%h exp=%h", k, obs_q(), exp_q());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < S; i++) m[i] = '0;
        test_reset();
        test_tnew_forward();
        test_stall();
        test_flush();
        test_nearest();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_chain_reg.md
# pipe_chain_reg

Parametrised chain of `STAGES` pipeline registers carrying PC, instruction, destination register, write-enable, forwardable result, sideband payload and a saturating Tnew counter. Each stage has independent enable (stall) and flush (bubble) control. Built-in two-port hazard query scans all stages, nearest first, and returns a forward hit, the forwarded data or a stall request. It sits between the execute and writeback sides of the CPU pipeline and replaces the hand-written per-stage registers and their hazard lookup.

## Interface
- `STAGES`, 2: number of register stages; stage 0 is youngest; range 1..8.
- `DATA_W`, 32: width of PC, instruction and result fields.
- `SIDE_W`, 8: sideband payload width (e.g. DatatoReg select); carried, never interpreted.
- `TNEW_W`, 4: Tnew/Tuse width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `en` in STAGES: per-stage capture enable; bit i = 1 loads stage i.
- `flush` in STAGES: per-stage bubble insert; overrides `en`.
- `in_pc`, `in_instr`, `in_res` in DATA_W each: stage 0 inputs.
- `in_a3` in 5: destination register.
- `in_write` in 1: register write request.
- `in_side` in SIDE_W: sideband.
- `in_tnew` in TNEW_W: cycles until result ready, at stage 0 input.
- `out_pc`, `out_instr`, `out_res` out DATA_W: last stage contents.
- `out_a3` out 5, `out_write` out 1, `out_side` out SIDE_W, `out_tnew` out TNEW_W: last stage contents.
- `stg_valid` out STAGES: per-stage valid bit.
- `q_addr0`, `q_addr1` in 5: query register addresses.
- `q_tuse0`, `q_tuse1` in TNEW_W: consumer's Tuse for each query.
- `q_hit0`, `q_hit1` out 1: forward available.
- `q_data0`, `q_data1` out DATA_W: forwarded value.
- `q_stall0`, `q_stall1` out 1: consumer must stall.

## Operation
- Stage i source: `in_*` for i = 0; stage i-1 contents otherwise.
- Reset (`reset` = 0): every field 0 in every stage, including valid, write, a3, tnew, pc, instr, res, side; all outputs 0.
- `flush[i]` = 1: stage i becomes a bubble: valid=0, write=0, a3=0, tnew=0, instr=0; pc loaded from source (kept for exception reporting); res, side loaded from source. Independent of `en[i]`.
- `en[i]` = 1, `flush[i]` = 0: stage i loads its source. valid=1 for stage 0, else copies stage i-1 valid. write forced to 0 when source a3 = 0. tnew = source tnew − 1, saturating at 0.
- `en[i]` = 0, `flush[i]` = 0: stage i holds all fields, tnew included (no countdown while stalled).
- Stages are independent: loading stage i while stage i-1 holds duplicates i-1; the upstream control must flush i when appropriate.
- Query (combinational from registered state only; no combinational path from `in_*`, `en` or `flush`):
  - candidate stage: valid=1, write=1, a3 = q_addr, a3 ≠ 0;
  - lowest-index candidate only decides; older matches ignored;
  - candidate tnew = 0: hit=1, data=res, stall=0;
  - candidate tnew > q_tuse: stall=1, hit=0, data=0;
  - otherwise (0 < tnew ≤ q_tuse): hit=0, stall=0, data=0;
  - no candidate or q_addr = 0: hit=0, stall=0, data=0.
- Ports 0 and 1 are fully independent and may query the same address.

## Timing
- Latency: stage 0 through stage `STAGES-1` takes `STAGES` rising edges with all `en` = 1.
- Tnew at output = max(in_tnew − STAGES, 0) with no stalls.
- Reset assertion is asynchronous. Release is sampled: the first capture occurs on the first rising edge with `reset` = 1.
- Query outputs settle in the same cycle as register updates; they are combinational from register state.

## Test plan
- Reset mid-stream: fill with valid entries, drop `reset` between edges -> all outputs and `stg_valid` 0 before next edge.
- STAGES=2, in_tnew=3, a3=5, write=1, en=11 for 2 edges -> out_tnew=1; query addr 5 tuse 0 -> stall=1; after the next edge (tnew 0) -> hit=1, data=in_res.
- Stall: en=01 for 3 cycles with stage 1 tnew=2 -> stage 1 tnew stays 2; stage 0 advances each edge.
- Flush priority: en=11, flush=10 -> stage 1 valid=0, write=0, a3=0, pc equals stage 0 pc; query on its old a3 returns no hit.
- Nearest wins: stage 0 a3=7 tnew=0 res=0xAAAA, stage 1 a3=7 res=0xBBBB -> q_data=0xAAAA; a3=0 with write=1 -> out_write=0 and no hit.
- Saturation: in_tnew=0 -> every stage tnew 0. TNEW_W=4 with in_tnew=15 -> output 13 after 2 edges.
